// File: rtl/axis_spectrum_pkg.sv
// rtl/axis_spectrum_pkg.sv - shared widths, field slices and frame default for the power-spectrum stage
package axis_spectrum_pkg;

    localparam int SAMPLE_W          = 16;
    localparam int DATA_W            = 32;
    localparam int FRAME_LEN_DEFAULT = 1024;

    // Packed complex bin layout on the input stream
    localparam int RE_MSB = 31;
    localparam int RE_LSB = 16;
    localparam int IM_MSB = 15;
    localparam int IM_LSB = 0;

endpackage

// File: rtl/cplx_mag_sq.sv
// rtl/cplx_mag_sq.sv - S2/S3 datapath: signed squares, then unsigned sum into the output register
module cplx_mag_sq
    import axis_spectrum_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] re,
    input  logic signed [SAMPLE_W-1:0] im,
    input  logic                       last_in,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          mag,
    output logic                       last_out
);

    logic                     p_valid;
    logic                     p_last;
    logic signed [DATA_W-1:0] p_re;
    logic signed [DATA_W-1:0] p_im;

    // S2: square each component; operands are sign-extended so the full 32-bit product is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_re    <= '0;
            p_im    <= '0;
        end else if (en) begin
            p_valid <= in_valid;
            p_last  <= last_in;
            p_re    <= DATA_W'(re) * DATA_W'(re);
            p_im    <= DATA_W'(im) * DATA_W'(im);
        end
    end

    // S3: both squares are non-negative and at most 2^30, so their unsigned sum cannot wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            last_out  <= 1'b0;
            mag       <= '0;
        end else if (en) begin
            out_valid <= p_valid;
            last_out  <= p_last;
            mag       <= $unsigned(p_re) + $unsigned(p_im);
        end
    end

endmodule

// File: rtl/axis_power_spectrum.sv
// rtl/axis_power_spectrum.sv - streaming |X|^2 stage with TLAST regeneration and frame-length checking
module axis_power_spectrum
    import axis_spectrum_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TVALID,
    input  logic              S_AXIS_TLAST,
    output logic              S_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    output logic              M_AXIS_TLAST,
    input  logic              M_AXIS_TREADY,
    output logic              LEN_ERR,
    output logic [15:0]       FRAME_CNT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic                       en;
    logic                       accept;
    logic                       at_end;
    logic                       last_tag;
    logic [CNT_W-1:0]           cnt;
    logic                       s1_valid;
    logic                       s1_last;
    logic signed [SAMPLE_W-1:0] s1_re;
    logic signed [SAMPLE_W-1:0] s1_im;

    // Whole pipeline moves in lockstep; it only freezes while the output beat is waiting
    assign en            = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign S_AXIS_TREADY = en;
    assign accept        = S_AXIS_TVALID && en;
    assign at_end        = (cnt == CNT_LAST);
    assign last_tag      = at_end || S_AXIS_TLAST;

    // S1: capture the beat and its last tag; the tag is masked on bubbles so it never leaks out
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else if (en) begin
            s1_valid <= S_AXIS_TVALID;
            s1_last  <= S_AXIS_TVALID && last_tag;
            s1_re    <= S_AXIS_TDATA[RE_MSB:RE_LSB];
            s1_im    <= S_AXIS_TDATA[IM_MSB:IM_LSB];
        end
    end

    // Bin counter; an upstream TLAST restarts the frame even when it arrives early
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= last_tag ? '0 : cnt + 1'b1;
        end
    end

    // Sticky flag for any upstream TLAST that disagrees with the fixed frame length
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            LEN_ERR <= 1'b0;
        end else if (accept && (at_end ^ S_AXIS_TLAST)) begin
            LEN_ERR <= 1'b1;
        end
    end

    // Count frames as they leave, on the handshake of their final bin
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            FRAME_CNT <= '0;
        end else if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
            FRAME_CNT <= FRAME_CNT + 16'd1;
        end
    end

    cplx_mag_sq u_mag (
        .clk       (ACLK),
        .rst       (ARESET),
        .en        (en),
        .in_valid  (s1_valid),
        .re        (s1_re),
        .im        (s1_im),
        .last_in   (s1_last),
        .out_valid (M_AXIS_TVALID),
        .mag       (M_AXIS_TDATA),
        .last_out  (M_AXIS_TLAST)
    );

endmodule

// File: tb/tb_axis_power_spectrum.sv
// tb/tb_axis_power_spectrum.sv - directed table-driven bench for axis_power_spectrum
module tb_axis_power_spectrum;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        len_err;
    logic [15:0] frame_cnt;

    axis_power_spectrum #(.FRAME_LEN(8)) dut (
        .ACLK          (aclk),
        .ARESET        (areset),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .LEN_ERR       (len_err),
        .FRAME_CNT     (frame_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } obeat_t;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               last;
        logic [31:0]        exp_mag;
        logic               exp_last;
    } vec_t;

    obeat_t      out_q[$];
    obeat_t      exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          first_acc = -1;
    int          first_out = -1;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;
    logic        done3;
    vec_t        tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gold(input int re, input int im);
        longint v;
        v = longint'(re) * re + longint'(im) * im;
        return v[31:0];
    endfunction

    always @(posedge aclk) cyc++;

    // Monitor at the falling edge: inputs are stable then, so valid&&ready predicts the next edge's handshake
    always @(negedge aclk) begin
        if (areset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("stall_hold_valid", {31'd0, m_tvalid}, 32'd1);
                chk("stall_hold_data", m_tdata, hold_d);
                chk("stall_hold_last", {31'd0, m_tlast}, {31'd0, hold_l});
            end
            hold_pending = m_tvalid && !m_tready;
            hold_d = m_tdata;
            hold_l = m_tlast;
            if (first_acc < 0 && s_tvalid && s_tready) first_acc = cyc + 1;
            if (first_out < 0 && m_tvalid) first_out = cyc;
            if (m_tvalid && m_tready) out_q.push_back('{m_tdata, m_tlast});
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat
    task automatic send(input int re, input int im, input logic last);
        int t;
        s_tdata  = {re[15:0], im[15:0]};
        s_tvalid = 1'b1;
        s_tlast  = last;
        t = 0;
        @(negedge aclk);
        while (!s_tready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (!s_tready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain_and_compare(input string name);
        int t;
        t = 0;
        while (out_q.size() < exp_q.size() && t < 1000) begin
            @(negedge aclk);
            t++;
        end
        repeat (6) @(negedge aclk);
        chk($sformatf("%s_count", name), out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            chk($sformatf("%s_data[%0d]", name, i), out_q[i].d, exp_q[i].d);
            chk($sformatf("%s_last[%0d]", name, i), {31'd0, out_q[i].l}, {31'd0, exp_q[i].l});
        end
        out_q.delete();
        exp_q.delete();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge aclk);
        #2 areset = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        out_q.delete();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        tbl[0] = '{-16'sd32768, -16'sd32768, 1'b0, 32'h8000_0000, 1'b0};
        tbl[1] = '{ 16'sd32767, -16'sd32768, 1'b0, 32'h7FFF_0001, 1'b0};
        tbl[2] = '{ 16'sd0,      16'sd0,     1'b0, 32'd0,         1'b0};
        tbl[3] = '{ 16'sd1,     -16'sd1,     1'b0, 32'd2,         1'b0};
        tbl[4] = '{-16'sd5,      16'sd12,    1'b0, 32'd169,       1'b0};
        tbl[5] = '{ 16'sd100,    16'sd0,     1'b0, 32'd10000,     1'b0};
        tbl[6] = '{ 16'sd0,     -16'sd200,   1'b0, 32'd40000,     1'b0};
        tbl[7] = '{ 16'sd181,    16'sd181,   1'b1, 32'd65522,     1'b1};

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_len_err", {31'd0, len_err}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("rst_s_tready", {31'd0, s_tready}, 32'd1);

        // Basic frame: 3+4j eight times, upstream TLAST on beat 8
        for (int i = 0; i < 8; i++) begin
            send(3, 4, i == 7);
            exp_q.push_back('{32'd25, i == 7});
        end
        drain_and_compare("basic");
        chk("latency_edges", first_out - first_acc + 1, 32'd3);
        chk("basic_len_err", {31'd0, len_err}, 32'd0);
        chk("basic_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // Corner magnitudes from the vector table, one full frame
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].re, tbl[i].im, tbl[i].last);
            exp_q.push_back('{tbl[i].exp_mag, tbl[i].exp_last});
        end
        drain_and_compare("corner");
        chk("corner_len_err", {31'd0, len_err}, 32'd0);
        chk("corner_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        // Three frames under random downstream backpressure
        for (int i = 0; i < 24; i++)
            exp_q.push_back('{gold(i * 1000 - 12000, 500 - i * 37), (i % 8) == 7});
        done3 = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) send(i * 1000 - 12000, 500 - i * 37, (i % 8) == 7);
                done3 = 1'b1;
            end
            begin
                while (!done3) begin
                    @(posedge aclk);
                    #1;
                    m_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_tready = 1'b1;
        drain_and_compare("stall");
        chk("stall_frame_cnt", {16'd0, frame_cnt}, 32'd5);

        // Early upstream TLAST on beat 5 resynchronises, then a full 8-beat frame
        for (int i = 0; i < 13; i++) begin
            send(i, 2, i == 4 || i == 12);
            exp_q.push_back('{gold(i, 2), i == 4 || i == 12});
        end
        drain_and_compare("early");
        chk("early_len_err", {31'd0, len_err}, 32'd1);
        chk("early_frame_cnt", {16'd0, frame_cnt}, 32'd7);

        pulse_reset();
        chk("clr_len_err", {31'd0, len_err}, 32'd0);
        chk("clr_frame_cnt", {16'd0, frame_cnt}, 32'd0);

        // Missing upstream TLAST: generated anyway, next beat opens a fresh frame
        for (int i = 0; i < 16; i++) begin
            send(-i, 7, i == 15);
            exp_q.push_back('{gold(-i, 7), i == 7 || i == 15});
        end
        drain_and_compare("missing");
        chk("missing_len_err", {31'd0, len_err}, 32'd1);
        chk("missing_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        pulse_reset();

        // Reset mid-frame with beats in flight and the output stalled
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(9, 9, 1'b0);
        chk("midrst_pre_valid", {31'd0, m_tvalid}, 32'd1);
        #2 areset = 1'b1;
        #1;
        chk("midrst_async_valid", {31'd0, m_tvalid}, 32'd0);
        chk("midrst_async_tlast", {31'd0, m_tlast}, 32'd0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        out_q.delete();
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(i + 1, -i, i == 7);
            exp_q.push_back('{gold(i + 1, -i), i == 7});
        end
        drain_and_compare("midrst");
        chk("midrst_len_err", {31'd0, len_err}, 32'd0);
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
